// File: rtl/mult32x32_pkg.sv
// Shared types and constants for the fast 32x32 multiplier: the control FSM
// and the 16x16-based arithmetic datapath both import this package.
package mult32x32_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A0B0 = 3'd1,
        A0B1 = 3'd2,
        A1B0 = 3'd3,
        A1B1 = 3'd4
    } mult_state_t;

    // Datapath shift applied to each 16x16 partial product before accumulation
    localparam logic [1:0] SHIFT_0  = 2'b00;
    localparam logic [1:0] SHIFT_16 = 2'b01;
    localparam logic [1:0] SHIFT_32 = 2'b10;

endpackage

// File: rtl/mult32x32_fast_fsm.sv
// Control FSM for the fast 32x32 multiplier: walks the four 16x16 partial
// products, skipping those with a zero MSW operand, and strobes the datapath.
import mult32x32_pkg::*;

module mult32x32_fast_fsm #(
    parameter bit SKIP_ZERO_MSW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       a_msw_is_0,
    input  logic       b_msw_is_0,
    output logic       busy,
    output logic       done,
    output logic       a_sel,
    output logic       b_sel,
    output logic [1:0] shift_sel,
    output logic       upd_prod,
    output logic       clr_prod
);

    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_A0B0 = A0B0;
    localparam logic [2:0] S_A0B1 = A0B1;
    localparam logic [2:0] S_A1B0 = A1B0;
    localparam logic [2:0] S_A1B1 = A1B1;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       in_compute;
    logic       skip_a0b1;
    logic       skip_a1b0;
    logic       skip_a1b1;

    // A product whose MSW operand is zero contributes nothing to the sum
    assign skip_a0b1 = SKIP_ZERO_MSW && b_msw_is_0;
    assign skip_a1b0 = SKIP_ZERO_MSW && a_msw_is_0;
    assign skip_a1b1 = SKIP_ZERO_MSW && (a_msw_is_0 || b_msw_is_0);

    assign in_compute = (state == S_A0B0) || (state == S_A0B1) ||
                        (state == S_A1B0) || (state == S_A1B1);

    always_comb begin
        // NOTE: assign a default before the case so every path drives
        // state_nxt; a missing branch would otherwise infer a latch.
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: state_nxt = start ? S_A0B0 : S_IDLE;
            S_A0B0: begin
                if (!skip_a0b1)      state_nxt = S_A0B1;
                else if (!skip_a1b0) state_nxt = S_A1B0;
                else if (!skip_a1b1) state_nxt = S_A1B1;
                else                 state_nxt = S_IDLE;
            end
            S_A0B1: begin
                if (!skip_a1b0)      state_nxt = S_A1B0;
                else if (!skip_a1b1) state_nxt = S_A1B1;
                else                 state_nxt = S_IDLE;
            end
            S_A1B0:  state_nxt = skip_a1b1 ? S_IDLE : S_A1B1;
            S_A1B1:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of block ordering.
        if (reset) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= in_compute && (state_nxt == S_IDLE);
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        shift_sel = SHIFT_0;
        upd_prod  = 1'b0;
        clr_prod  = (state == S_IDLE) && start && !reset;
        case (state)
            S_A0B0: begin
                upd_prod = 1'b1;
            end
            S_A0B1: begin
                b_sel     = 1'b1;
                shift_sel = SHIFT_16;
                upd_prod  = 1'b1;
            end
            S_A1B0: begin
                a_sel     = 1'b1;
                shift_sel = SHIFT_16;
                upd_prod  = 1'b1;
            end
            S_A1B1: begin
                a_sel     = 1'b1;
                b_sel     = 1'b1;
                shift_sel = SHIFT_32;
                upd_prod  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
